// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment codes are stored active-low; polarity is applied at the output stage.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    // Index = hex nibble, bit 6 = segment a ... bit 0 = segment g
    localparam logic [6:0] SEG_CODE_AL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment code.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_al
);

    assign seg_al = SEG_CODE_AL[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-slot blanking, PWM brightness,
// leading-zero suppression and frame-coherent input snapshots.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DIGIT_CYCLES   = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [6:0]              display_data,
    output logic                    display_dp,
    output logic [NUM_DIGITS-1:0]   display_en,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF_LVL = SEG_ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
    localparam logic [NUM_DIGITS-1:0] EN_OFF_LVL = {NUM_DIGITS{EN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] data_snap_r;
    logic [NUM_DIGITS-1:0]   dp_snap_r;
    logic [NUM_DIGITS-1:0]   mask_r;
    logic [3:0]              bright_r;

    logic                    frame_edge_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    phase_t                  phase_s;
    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   en_onehot_s;
    logic [3:0]              nib_s;
    logic [6:0]              seg_al_s;

    assign frame_edge_s = (cnt_r == {CNT_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});
    assign nib_s        = data_snap_r[{idx_r, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble (nib_s),
        .seg_al (seg_al_s)
    );

    // Leading-zero mask: scan down from the top digit until a nonzero nibble
    always_comb begin : lz_mask_calc
        logic seen;
        seen      = 1'b0;
        lz_mask_s = {NUM_DIGITS{1'b1}};
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen         = seen | (in_data[4*i +: 4] != 4'h0);
            lz_mask_s[i] = seen | ~lz_blank;
        end
    end

    // Slot phase and PWM gate for the digit currently being scanned
    always_comb begin
        if (cnt_r < CNT_BLANK) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_ON;
        end
        lit_s              = (phase_s == PH_ON) && mask_r[idx_r] && (cnt_r[3:0] <= bright_r);
        en_onehot_s        = {NUM_DIGITS{1'b0}};
        en_onehot_s[idx_r] = lit_s;
    end

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Frame snapshot so a value never tears across digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_snap_r <= {(4*NUM_DIGITS){1'b0}};
            dp_snap_r   <= {NUM_DIGITS{1'b0}};
            mask_r      <= {NUM_DIGITS{1'b0}};
            bright_r    <= 4'h0;
        end else if (frame_edge_s) begin
            data_snap_r <= in_data;
            dp_snap_r   <= dp_in;
            mask_r      <= lz_mask_s;
            bright_r    <= brightness;
        end else begin
            data_snap_r <= data_snap_r;
            dp_snap_r   <= dp_snap_r;
            mask_r      <= mask_r;
            bright_r    <= bright_r;
        end
    end

    // Output stage; segments park at the off level whenever no digit is lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_en   <= EN_OFF_LVL;
            display_data <= SEG_OFF_LVL;
            display_dp   <= SEG_ACTIVE_LOW;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= frame_edge_s;
            display_en  <= EN_ACTIVE_LOW ? ~en_onehot_s : en_onehot_s;
            if (lit_s) begin
                display_data <= SEG_ACTIVE_LOW ? seg_al_s : ~seg_al_s;
                display_dp   <= dp_snap_r[idx_r] ^ SEG_ACTIVE_LOW;
            end else begin
                display_data <= SEG_OFF_LVL;
                display_dp   <= SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based model queues the expected
// outputs at each clock edge and they are compared on the following falling edge.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int DC = 32;
    localparam int BC = 16;
    localparam int FRAME = ND * DC;
    localparam logic [12:0] OFF_V = {4'hF, 7'h7F, 1'b1, 1'b0};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   in_data = 16'hFFFF;
    logic [ND-1:0] dp_in = 4'hF;
    logic          lz_blank = 1'b1;
    logic [3:0]    brightness = 4'hF;
    logic [6:0]    display_data;
    logic          display_dp;
    logic [ND-1:0] display_en;
    logic          frame_start;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    logic [12:0] sb[$];
    int          m_t = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_br = 4'h0;
    logic [3:0]  m_mask = 4'h0;

    int          lit_c [ND];
    logic [7:0]  sd_c [ND];
    int          var_c [ND];
    int          first_c;
    int          fs_n;
    int          fs_pos [2];

    seg7_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .DIGIT_CYCLES   (DC),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .dp_in        (dp_in),
        .lz_blank     (lz_blank),
        .brightness   (brightness),
        .display_data (display_data),
        .display_dp   (display_dp),
        .display_en   (display_en),
        .frame_start  (frame_start)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic lz);
        logic [3:0] m;
        logic seen;
        m = 4'b0001;
        seen = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'h0) seen = 1'b1;
            m[i] = seen || !lz;
        end
        return m;
    endfunction

    // Expected outputs after the edge at time index t (t edges since reset release)
    function automatic logic [12:0] expect_out(input int t);
        int cnt, idx;
        logic lit;
        logic [3:0] en;
        logic [6:0] seg;
        logic dp;
        cnt = t % DC;
        idx = (t / DC) % ND;
        lit = (cnt >= BC) && m_mask[idx] && ((cnt % 16) <= int'(m_br));
        en = 4'hF;
        seg = 7'h7F;
        dp = 1'b1;
        if (lit) begin
            en[idx] = 1'b0;
            seg = SEG_TAB[m_data[4*idx +: 4]];
            dp = ~m_dp[idx];
        end
        return {en, seg, dp, (cnt == 0 && idx == 0)};
    endfunction

    task automatic step();
        logic [12:0] e, a;
        @(posedge clk);
        if (!rst_n) begin
            sb.push_back(OFF_V);
            m_t = 0; m_data = 16'h0; m_dp = 4'h0; m_br = 4'h0; m_mask = 4'h0;
        end else begin
            sb.push_back(expect_out(m_t));
            if (m_t % FRAME == 0) begin
                m_data = in_data;
                m_dp = dp_in;
                m_br = brightness;
                m_mask = lz_mask(in_data, lz_blank);
            end
            m_t++;
        end
        @(negedge clk);
        e = sb.pop_front();
        a = {display_en, display_data, display_dp, frame_start};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d got=%h exp=%h", ncyc, a, e);
        end
        ncyc++;
    endtask

    task automatic capture(input int n);
        for (int d = 0; d < ND; d++) begin
            lit_c[d] = 0; sd_c[d] = 8'h00; var_c[d] = 0;
        end
        first_c = -1;
        fs_n = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (frame_start === 1'b1) begin
                if (fs_n < 2) fs_pos[fs_n] = i;
                fs_n++;
            end
            for (int d = 0; d < ND; d++) begin
                if (display_en === ~(4'b0001 << d)) begin
                    if (lit_c[d] > 0 && sd_c[d] !== {display_data, display_dp}) var_c[d]++;
                    sd_c[d] = {display_data, display_dp};
                    lit_c[d]++;
                    if (first_c < 0) first_c = d;
                end
            end
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_start === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_frame got=timeout exp=frame_start within 300 cycles");
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({display_en, display_data, display_dp, frame_start} !== OFF_V) begin
            errors++;
            $display("FAIL reset got=%h exp=%h",
                     {display_en, display_data, display_dp, frame_start}, OFF_V);
        end
    endtask

    task automatic test_full_scan();
        in_data = 16'h12AF; dp_in = 4'h0; lz_blank = 1'b0; brightness = 4'hF;
        rst_n = 1'b1;
        capture(2 * FRAME);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (lit_c[d] !== 32 || var_c[d] !== 0) begin
                errors++;
                $display("FAIL scan_lit d=%0d got=%0d/%0d exp=32/0", d, lit_c[d], var_c[d]);
            end
        end
        checks++;
        if (sd_c[0] !== {7'b0111000, 1'b1}) begin
            errors++;
            $display("FAIL scan_digit0 got=%b exp=%b", sd_c[0], {7'b0111000, 1'b1});
        end
        checks++;
        if (sd_c[3] !== {7'b1001111, 1'b1}) begin
            errors++;
            $display("FAIL scan_digit3 got=%b exp=%b", sd_c[3], {7'b1001111, 1'b1});
        end
        checks++;
        if (fs_n !== 2 || fs_pos[0] !== 0 || fs_pos[1] - fs_pos[0] !== FRAME) begin
            errors++;
            $display("FAIL frame_period got=n%0d,%0d,%0d exp=n2,0,128", fs_n, fs_pos[0], fs_pos[1]);
        end
    endtask

    task automatic test_leading_zeros();
        in_data = 16'h0050; lz_blank = 1'b1; dp_in = 4'hF;
        wait_frame();
        capture(FRAME - 1);
        checks++;
        if (lit_c[3] !== 0 || lit_c[2] !== 0 || lit_c[1] !== 16 || lit_c[0] !== 16) begin
            errors++;
            $display("FAIL lz_lit got=%0d,%0d,%0d,%0d exp=0,0,16,16",
                     lit_c[3], lit_c[2], lit_c[1], lit_c[0]);
        end
        checks++;
        if (sd_c[1] !== {7'b0100100, 1'b0} || sd_c[0] !== {7'b0000001, 1'b0}) begin
            errors++;
            $display("FAIL lz_seg got=%b,%b exp=%b,%b", sd_c[1], sd_c[0],
                     {7'b0100100, 1'b0}, {7'b0000001, 1'b0});
        end
        in_data = 16'h0000;
        wait_frame();
        capture(FRAME - 1);
        checks++;
        if (lit_c[3] !== 0 || lit_c[2] !== 0 || lit_c[1] !== 0 || lit_c[0] !== 16) begin
            errors++;
            $display("FAIL lz_zero got=%0d,%0d,%0d,%0d exp=0,0,0,16",
                     lit_c[3], lit_c[2], lit_c[1], lit_c[0]);
        end
    endtask

    task automatic test_brightness();
        logic [3:0] levels [2];
        levels[0] = 4'd0;
        levels[1] = 4'd7;
        in_data = 16'h12AF; lz_blank = 1'b0; dp_in = 4'h0;
        for (int k = 0; k < 2; k++) begin
            brightness = levels[k];
            wait_frame();
            capture(FRAME - 1);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (lit_c[d] !== int'(levels[k]) + 1) begin
                    errors++;
                    $display("FAIL bright%0d d=%0d got=%0d exp=%0d", levels[k], d,
                             lit_c[d], int'(levels[k]) + 1);
                end
            end
        end
    endtask

    task automatic test_coherency();
        in_data = 16'h1234; brightness = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
        wait_frame();
        capture(DC - 1);
        in_data = 16'h5678;
        capture(FRAME - DC);
        checks++;
        if (sd_c[3] !== {SEG_TAB[1], 1'b1} || sd_c[1] !== {SEG_TAB[3], 1'b1} || var_c[3] !== 0) begin
            errors++;
            $display("FAIL coherent_old got=%b,%b exp=%b,%b", sd_c[3], sd_c[1],
                     {SEG_TAB[1], 1'b1}, {SEG_TAB[3], 1'b1});
        end
        wait_frame();
        capture(FRAME - 1);
        checks++;
        if (sd_c[3] !== {SEG_TAB[5], 1'b1} || sd_c[0] !== {SEG_TAB[8], 1'b1}) begin
            errors++;
            $display("FAIL coherent_new got=%b,%b exp=%b,%b", sd_c[3], sd_c[0],
                     {SEG_TAB[5], 1'b1}, {SEG_TAB[8], 1'b1});
        end
    endtask

    task automatic test_mid_reset();
        in_data = 16'h1234; brightness = 4'hF;
        wait_frame();
        capture(2 * DC + 20);
        checks++;
        if (display_en !== 4'b1011) begin
            errors++;
            $display("FAIL midrst_pre got=%b exp=%b", display_en, 4'b1011);
        end
        #2 rst_n = 1'b0;
        in_data = 16'h9ABC;
        #1;
        checks++;
        if ({display_en, display_data, display_dp, frame_start} !== OFF_V) begin
            errors++;
            $display("FAIL midrst_async got=%h exp=%h",
                     {display_en, display_data, display_dp, frame_start}, OFF_V);
        end
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        capture(FRAME);
        checks++;
        if (fs_n < 1 || fs_pos[0] !== 0 || first_c !== 0) begin
            errors++;
            $display("FAIL midrst_restart got=fs%0d@%0d,first%0d exp=fs@0,first0",
                     fs_n, fs_pos[0], first_c);
        end
        checks++;
        if (sd_c[0] !== {SEG_TAB[12], 1'b1} || lit_c[2] !== 16) begin
            errors++;
            $display("FAIL midrst_snapshot got=%b,%0d exp=%b,16", sd_c[0], lit_c[2],
                     {SEG_TAB[12], 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_leading_zeros();
        test_brightness();
        test_coherency();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the board's common-anode LED digit banks. It replaces the free-running per-clock digit scan with three additions: a programmable per-digit dwell, anti-ghosting blank time between digits, and 16-level PWM brightness. It also supports leading-zero suppression and per-digit decimal points. Frame-coherent snapshots of the displayed value prevent tearing. It sits between the CPU debug/register-view bus and the board pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- DIGIT_CYCLES, 1024, clk cycles per digit slot; multiple of 16, ≥ 32
- BLANK_CYCLES, 16, leading cycles of each slot with all digits off; multiple of 16, ≥ 16, < DIGIT_CYCLES
- SEG_ACTIVE_LOW, 1, 1 = segment/dp pins lit when 0
- EN_ACTIVE_LOW, 1, 1 = digit enables active when 0
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i
- dp_in  in  NUM_DIGITS  decimal point request per digit
- lz_blank  in  1  suppress leading zeros
- brightness  in  4  0 = 1/16 duty … 15 = full duty
- display_data  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a
- display_dp  out  1  decimal point
- display_en  out  NUM_DIGITS  one-hot digit enable
- frame_start  out  1  one-cycle pulse per frame

## Operation
- Counters: slot counter cnt (0..DIGIT_CYCLES-1) and digit index idx (0..NUM_DIGITS-1).
  - idx advances when cnt wraps.
  - idx wraps NUM_DIGITS-1 → 0.
  - Scan order: ascending from digit 0.
- Snapshot: on every posedge with cnt==0 && idx==0, register in_data, dp_in and brightness.
  - Also register a lit-mask computed from in_data and lz_blank.
  - Input changes at any other time are not displayed until the next frame.
- Leading-zero mask: with lz_blank=1, digits from NUM_DIGITS-1 downward whose nibble is 0 are unlit, stopping at the first nonzero nibble.
  - Digit 0 is always lit.
  - Decimal point of a suppressed digit is also off.
- Per-slot phases:
  - BLANK (cnt < BLANK_CYCLES): all enables inactive.
  - ON (cnt ≥ BLANK_CYCLES): digit idx enabled iff its mask bit is 1 and cnt[3:0] ≤ snapshot brightness.
- Segment codes (active-low form):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000, c=1110010, d=1000010, E=0110000, F=0111000
  - All bits are inverted when SEG_ACTIVE_LOW=0.
- When no digit is enabled, display_data and display_dp are driven to the all-off level.
- Reset values:
  - cnt, idx, all snapshot registers and mask = 0.
  - frame_start = 0.
  - display_en and display_data/display_dp at their inactive/off levels.

## Timing
- All outputs are registered. Outputs in cycle t reflect (idx, cnt, snapshot) of cycle t-1.
- frame_start is high for exactly one cycle: the cycle after each snapshot edge.
- The first snapshot occurs on the first posedge after rst_n deasserts.
- Frame period = NUM_DIGITS*DIGIT_CYCLES clk cycles.
- Lit cycles per slot = (brightness+1)*(DIGIT_CYCLES-BLANK_CYCLES)/16.
- Ghost-free switching: an enable never goes active in the same cycle that display_data changes digit. The BLANK phase guarantees this.
- rst_n assertion mid-frame forces all outputs off asynchronously. Scan restarts at digit 0, cnt 0.

## Structure
- Package seg7_pkg holds:
  - the 16-entry active-low segment-code constant array,
  - SEG_OFF_AL = 7'b1111111,
  - the phase enum {PH_BLANK, PH_ON}.
- Sub-module seg7_hex_decode: combinational nibble → 7-bit active-low code, using the package table. Polarity inversion is applied in seg7_scan_ctrl.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with any inputs → display_en all 1, display_data=1111111, display_dp=1, frame_start=0.
- Full scan with NUM_DIGITS=4, DIGIT_CYCLES=32, BLANK_CYCLES=16, brightness=15, in_data=16'h12AF, lz_blank=0:
  - each slot shows 16 dark cycles then 16 lit cycles;
  - digit0 shows 0111000 (F), digit3 shows 1001111 (1);
  - frame_start pulses every 128 cycles.
- Leading zeros: in_data=16'h0050, lz_blank=1, dp_in=4'b1111 → digits 3 and 2 never enabled; digit1=0100100 (5) with dp; digit0=0000001 (0). in_data=0 → only digit0 lit.
- Brightness: brightness=0 → exactly 1 lit cycle per 16 in the ON phase (1 per slot). brightness=7 → 8 lit cycles per slot.
- Snapshot coherency: change in_data mid-frame → displayed digits are unchanged until the cycle after the next frame_start.
- Mid-scan reset: assert rst_n during digit 2 ON phase → outputs off immediately. After release, the scan restarts at digit0 with a fresh snapshot.
